// File: rtl/odometer.sv
// Odometer: debounced reed-switch pulse counter that accumulates wheel
// circumference in cm and maintains trip and total distance counters.
module odometer #(
  parameter int CIRC_W     = 8,
  parameter int FRAC_LIMIT = 10000,
  parameter int FRAC_W     = 14,
  parameter int DIST_W     = 14,
  parameter int DIST_MAX   = 9999,
  parameter int HOLD_W     = 8,
  parameter int WRAP       = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              reed,
  input  logic              enable,
  input  logic [CIRC_W-1:0] circ,
  input  logic [HOLD_W-1:0] holdoff,
  input  logic              trip_clear,
  output logic [DIST_W-1:0] trip_dist,
  output logic [DIST_W-1:0] total_dist,
  output logic [FRAC_W-1:0] frac_cm,
  output logic              wheel_pulse,
  output logic              trip_wrap,
  output logic              total_wrap,
  output logic              trip_sat
);

  // One spare bit so frac_cm + circ never overflows before the compare.
  localparam int SUM_W = FRAC_W + 1;
  localparam logic [SUM_W-1:0]  LIMIT   = SUM_W'(FRAC_LIMIT);
  localparam logic [DIST_W-1:0] MAX_VAL = DIST_W'(DIST_MAX);

  logic              reed_q;
  logic [HOLD_W-1:0] hold_cnt;
  logic              total_sat;
  logic              accept;
  logic [SUM_W-1:0]  sum;
  logic              carry;

  // A pulse is a fresh rising edge, enabled, outside the debounce window.
  assign accept = reed & ~reed_q & enable & (hold_cnt == '0);
  assign sum    = {1'b0, frac_cm} + SUM_W'(circ);
  assign carry  = accept & (sum >= LIMIT);

  // Reed edge detector and debounce holdoff counter.
  always_ff @(posedge clock) begin
    // NOTE: all state in always_ff uses non-blocking assignment so every
    // register sees the pre-edge values of the others.
    if (reset) begin
      // reed_q comes out of reset high so a reed held high across reset
      // release is not mistaken for a rising edge.
      reed_q   <= 1'b1;
      hold_cnt <= '0;
    end else begin
      reed_q <= reed;
      if (accept) begin
        hold_cnt <= holdoff;
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HOLD_W'(1);
      end
    end
  end

  // Fractional cm accumulator and the per-pulse strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      frac_cm     <= '0;
      wheel_pulse <= 1'b0;
    end else begin
      wheel_pulse <= accept;
      if (accept) begin
        // Keep the remainder past the unit boundary so no distance is lost.
        frac_cm <= carry ? FRAC_W'(sum - LIMIT) : FRAC_W'(sum);
      end
    end
  end

  // Total distance counter; only reset can clear it.
  always_ff @(posedge clock) begin
    if (reset) begin
      total_dist <= '0;
      total_wrap <= 1'b0;
      total_sat  <= 1'b0;
    end else begin
      total_wrap <= 1'b0;
      if (carry) begin
        if (total_dist == MAX_VAL) begin
          if (WRAP != 0) begin
            total_dist <= '0;
            total_wrap <= 1'b1;
          end else if (!total_sat) begin
            // Saturated: value holds, strobe only on the first blocked step.
            total_sat  <= 1'b1;
            total_wrap <= 1'b1;
          end
        end else begin
          total_dist <= total_dist + DIST_W'(1);
        end
      end
    end
  end

  // Trip distance counter; trip_clear wins over a coincident carry.
  always_ff @(posedge clock) begin
    if (reset) begin
      trip_dist <= '0;
      trip_wrap <= 1'b0;
      trip_sat  <= 1'b0;
    end else begin
      trip_wrap <= 1'b0;
      if (trip_clear) begin
        trip_dist <= '0;
        trip_sat  <= 1'b0;
      end else if (carry) begin
        if (trip_dist == MAX_VAL) begin
          if (WRAP != 0) begin
            trip_dist <= '0;
            trip_wrap <= 1'b1;
          end else if (!trip_sat) begin
            trip_sat  <= 1'b1;
            trip_wrap <= 1'b1;
          end
        end else begin
          trip_dist <= trip_dist + DIST_W'(1);
        end
      end
    end
  end

endmodule
